// File: rtl/load_store_multi_pkg.sv
// Shared types and configuration checks for the load_store_multi level oscillator.
// Optional IRQ logic is enabled by defining LOAD_STORE_IRQ_EN.
package load_store_pkg;

  typedef enum logic {DRAIN = 1'b0, FILL = 1'b1} dir_e;

  localparam int unsigned DEF_N     = 1250;
  localparam int unsigned DEF_STEP  = 1;
  localparam int unsigned DEF_CBITS = 11;

  // Legal configuration: N fits in CBITS, 1 <= STEP <= N, at least one channel.
  function automatic bit cfg_ok(int unsigned ch, int unsigned n, int unsigned step,
                                int unsigned cbits, int unsigned pbits);
    return (ch >= 1) && (n >= 1) && (step >= 1) && (step <= n) &&
           (cbits >= 1) && (cbits < 32) && ((n >> cbits) == 0) && (pbits >= 1);
  endfunction

endpackage

// File: rtl/load_store_multi_chan.sv
// One fill/drain channel: volume ramp, direction, flags, saturating period count.
// With LOAD_STORE_IRQ_EN a sticky bit latches each rising edge of at_top.
module load_store_chan
  import load_store_pkg::*;
#(
  parameter int unsigned CBITS = DEF_CBITS,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned STEP  = DEF_STEP,
  parameter int unsigned PBITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CBITS-1:0] vol_o,
  output logic             dir_o,
  output logic             at_top_o,
  output logic             at_bot_o,
  output logic [PBITS-1:0] periods_o
`ifdef LOAD_STORE_IRQ_EN
  ,
  input  logic             irq_clr_i,
  output logic             sticky_o
`endif
);

  localparam logic [CBITS-1:0] N_V    = CBITS'(N);
  localparam logic [CBITS-1:0] STEP_V = CBITS'(STEP);

  logic [CBITS-1:0] vol_q, vol_d;
  dir_e             dir_q, dir_d;
  logic             at_top_q, at_top_d;
  logic             at_bot_q, at_bot_d;
  logic [PBITS-1:0] periods_q, periods_d;
  logic             first_q, first_d;
  logic [CBITS:0]   sum;

  always_comb begin
    vol_d     = vol_q;
    dir_d     = dir_q;
    periods_d = periods_q;
    first_d   = first_q;
    sum       = {1'b0, vol_q} + {1'b0, STEP_V};
    if (en_i) begin
      unique case (dir_q)
        FILL: begin
          if (vol_q >= N_V) dir_d = DRAIN;
          else if (sum > {1'b0, N_V}) vol_d = N_V;
          else vol_d = sum[CBITS-1:0];
        end
        DRAIN: begin
          if (vol_q == '0) begin
            dir_d   = FILL;
            first_d = 1'b1;
            // The very first bottom turn after reset does not close a period.
            if (first_q && (periods_q != '1)) periods_d = periods_q + 1'b1;
          end else if (vol_q < STEP_V) begin
            vol_d = '0;
          end else begin
            vol_d = vol_q - STEP_V;
          end
        end
        default: ;
      endcase
    end
    at_top_d = (vol_d == N_V);
    at_bot_d = (vol_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vol_q     <= '0;
      dir_q     <= DRAIN;
      at_top_q  <= 1'b0;
      at_bot_q  <= 1'b1;
      periods_q <= '0;
      first_q   <= 1'b0;
    end else begin
      vol_q     <= vol_d;
      dir_q     <= dir_d;
      at_top_q  <= at_top_d;
      at_bot_q  <= at_bot_d;
      periods_q <= periods_d;
      first_q   <= first_d;
    end
  end

`ifdef LOAD_STORE_IRQ_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = (at_top_d & ~at_top_q) | (sticky_q & ~irq_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_o = sticky_q;
`endif

  assign vol_o     = vol_q;
  assign dir_o     = dir_q;
  assign at_top_o  = at_top_q;
  assign at_bot_o  = at_bot_q;
  assign periods_o = periods_q;

endmodule

// File: rtl/load_store_multi.sv
// Multi-channel fill/drain level oscillator: CH independent load_store_chan instances.
// Define LOAD_STORE_IRQ_EN to add irq/irq_clr and the per-channel sticky bits.
module load_store_multi
  import load_store_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned CBITS = DEF_CBITS,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned STEP  = DEF_STEP,
  parameter int unsigned PBITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       en,
  output logic [CH*CBITS-1:0] vol,
  output logic [CH-1:0]       dir,
  output logic [CH-1:0]       at_top,
  output logic [CH-1:0]       at_bot,
  output logic [CH*PBITS-1:0] periods
`ifdef LOAD_STORE_IRQ_EN
  ,
  output logic                irq,
  input  logic [CH-1:0]       irq_clr
`endif
);

  if (!cfg_ok(CH, N, STEP, CBITS, PBITS)) begin : g_bad_cfg
    $error("load_store_multi: illegal CH/N/STEP/CBITS/PBITS combination");
  end

`ifdef LOAD_STORE_IRQ_EN
  logic [CH-1:0] sticky;
  logic          irq_q;
`endif

  for (genvar c = 0; c < CH; c++) begin : g_chan
    load_store_chan #(
      .CBITS(CBITS),
      .N    (N),
      .STEP (STEP),
      .PBITS(PBITS)
    ) u_chan (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (en[c]),
      .vol_o    (vol[c*CBITS +: CBITS]),
      .dir_o    (dir[c]),
      .at_top_o (at_top[c]),
      .at_bot_o (at_bot[c]),
      .periods_o(periods[c*PBITS +: PBITS])
`ifdef LOAD_STORE_IRQ_EN
      ,
      .irq_clr_i(irq_clr[c]),
      .sticky_o (sticky[c])
`endif
    );
  end

`ifdef LOAD_STORE_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |sticky;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_load_store_multi.sv
// Self-checking bench for load_store_multi: vector table, corner sequences,
// randomized run against an integer reference model, and a default-parameter timing check.
module tb_load_store_multi;

  localparam int CH = 2, CB = 4, NN = 5, ST = 2, PB = 2;
  localparam int PMAX = (1 << PB) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CH-1:0]     en  = '0;
  logic [CH*CB-1:0]  vol;
  logic [CH-1:0]     dir, at_top, at_bot;
  logic [CH*PB-1:0]  periods;

  logic              rst2 = 1'b0;
  logic [3:0]        en2  = '0;
  logic [4*11-1:0]   vol2;
  logic [3:0]        dir2, at_top2, at_bot2;
  logic [4*8-1:0]    periods2;

`ifdef LOAD_STORE_IRQ_EN
  logic              irq, irq2;
  logic [CH-1:0]     irq_clr = '0;
  logic [3:0]        irq_clr2 = '0;
`endif

  always #5 clk = ~clk;

  load_store_multi #(.CH(CH), .CBITS(CB), .N(NN), .STEP(ST), .PBITS(PB)) dut (
    .clk(clk), .rst(rst), .en(en), .vol(vol), .dir(dir),
    .at_top(at_top), .at_bot(at_bot), .periods(periods)
`ifdef LOAD_STORE_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  load_store_multi dut2 (
    .clk(clk), .rst(rst2), .en(en2), .vol(vol2), .dir(dir2),
    .at_top(at_top2), .at_bot(at_bot2), .periods(periods2)
`ifdef LOAD_STORE_IRQ_EN
    , .irq(irq2), .irq_clr(irq_clr2)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int vol_of(input int c);
    return int'(vol[c*CB +: CB]);
  endfunction

  function automatic int per_of(input int c);
    return int'(periods[c*PB +: PB]);
  endfunction

  // Reference model: plain integer arithmetic over the spec's ramp rules.
  int m_vol[CH], m_dir[CH], m_seen[CH], m_per[CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_vol[c] = 0; m_dir[c] = 0; m_seen[c] = 0; m_per[c] = 0;
    end
  endtask

  task automatic model_step(input logic [CH-1:0] e);
    for (int c = 0; c < CH; c++) begin
      if (!e[c]) continue;
      if (m_dir[c] == 1) begin
        if (m_vol[c] >= NN) m_dir[c] = 0;
        else m_vol[c] = (m_vol[c] + ST > NN) ? NN : m_vol[c] + ST;
      end else if (m_vol[c] == 0) begin
        m_dir[c] = 1;
        if (m_seen[c] != 0 && m_per[c] < PMAX) m_per[c]++;
        m_seen[c] = 1;
      end else begin
        m_vol[c] = (m_vol[c] - ST < 0) ? 0 : m_vol[c] - ST;
      end
    end
  endtask

  task automatic model_compare(input string tag);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s ch%0d vol", tag, c), vol_of(c), m_vol[c]);
      chk($sformatf("%s ch%0d dir", tag, c), int'(dir[c]), m_dir[c]);
      chk($sformatf("%s ch%0d at_top", tag, c), int'(at_top[c]), int'(m_vol[c] == NN));
      chk($sformatf("%s ch%0d at_bot", tag, c), int'(at_bot[c]), int'(m_vol[c] == 0));
      chk($sformatf("%s ch%0d periods", tag, c), per_of(c), m_per[c]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int v, d, t, b, p;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Ramp seen on ch0 with N=5, STEP=2 for the first ten enabled edges.
    tbl[0] = '{0, 1, 0, 1, 0};
    tbl[1] = '{2, 1, 0, 0, 0};
    tbl[2] = '{4, 1, 0, 0, 0};
    tbl[3] = '{5, 1, 1, 0, 0};
    tbl[4] = '{5, 0, 1, 0, 0};
    tbl[5] = '{3, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 1, 0};
    tbl[8] = '{0, 1, 0, 1, 1};
    tbl[9] = '{2, 1, 0, 0, 1};

    tick();
    do_reset();
    for (int c = 0; c < CH; c++) begin
      chk("reset vol", vol_of(c), 0);
      chk("reset dir", int'(dir[c]), 0);
      chk("reset at_top", int'(at_top[c]), 0);
      chk("reset at_bot", int'(at_bot[c]), 1);
      chk("reset periods", per_of(c), 0);
    end

    // Table: ch0 enabled, ch1 disabled and must hold its reset state.
    en = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("tbl%0d vol0", i), vol_of(0), tbl[i].v);
      chk($sformatf("tbl%0d dir0", i), int'(dir[0]), tbl[i].d);
      chk($sformatf("tbl%0d top0", i), int'(at_top[0]), tbl[i].t);
      chk($sformatf("tbl%0d bot0", i), int'(at_bot[0]), tbl[i].b);
      chk($sformatf("tbl%0d per0", i), per_of(0), tbl[i].p);
      chk($sformatf("tbl%0d vol1", i), vol_of(1), 0);
      chk($sformatf("tbl%0d dir1", i), int'(dir[1]), 0);
      chk($sformatf("tbl%0d bot1", i), int'(at_bot[1]), 1);
    end

    // Reset mid-ramp while filling at vol=4.
    do_reset();
    en = 2'b11;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        if (vol_of(0) == 4 && dir[0] == 1'b1) break;
        tick();
      end
      chk("midramp reach vol4", int'(k < 20), 1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midramp vol", vol_of(0), 0);
    chk("midramp dir", int'(dir[0]), 0);
    chk("midramp at_bot", int'(at_bot[0]), 1);
    chk("midramp periods", per_of(0), 0);

    // Saturation: 6+ full periods (8 edges each) with a 2-bit counter.
    en = 2'b11;
    for (int i = 0; i < 60; i++) tick();
    chk("sat periods0", per_of(0), 3);
    chk("sat periods1", per_of(1), 3);

    // Randomized enables with occasional resets against the model.
    do_reset();
    model_reset();
    model_compare("rnd0");
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      en  = CH'($urandom);
      tick();
      if (rst) model_reset();
      else     model_step(en);
      model_compare($sformatf("rnd%0d", i + 1));
    end
    rst = 1'b0;

`ifdef LOAD_STORE_IRQ_EN
    do_reset();
    en = 2'b01;
    irq_clr = '0;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        tick();
        if (at_top[0]) break;
      end
      chk("irq rise found", int'(k < 20), 1);
    end
    chk("irq before set", int'(irq), 0);
    tick();
    chk("irq after rise", int'(irq), 1);
    irq_clr = 2'b01;
    tick();
    irq_clr = '0;
    tick();
    chk("irq cleared", int'(irq), 0);
    begin
      int k;
      for (k = 0; k < 30; k++) begin
        if (vol_of(0) == 4 && dir[0] == 1'b1) break;
        tick();
      end
      chk("irq reach pre-rise", int'(k < 30), 1);
    end
    irq_clr = 2'b01;
    tick();
    irq_clr = '0;
    chk("irq coincident top", int'(at_top[0]), 1);
    tick();
    chk("irq set wins", int'(irq), 1);
`endif

    // Default parameters: first top at edge 1251, high 2 edges, period 2502.
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    en2 = 4'hF;
    begin
      int first_rise = -1, second_rise = -1, high_len = 0;
      logic prev = 1'b0;
      for (int e = 1; e <= 4000; e++) begin
        tick();
        if (at_top2[0] && !prev) begin
          if (first_rise < 0) first_rise = e;
          else if (second_rise < 0) second_rise = e;
        end
        if (at_top2[0] && second_rise < 0) high_len++;
        prev = at_top2[0];
        if (second_rise >= 0) break;
      end
      chk("dflt first top edge", first_rise, 1251);
      chk("dflt top high edges", high_len, 2);
      chk("dflt period edges", second_rise - first_rise, 2502);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
